// File: rtl/io_input_conditioner.sv
// io_input_conditioner: synchronises, debounces and edge-detects board switches and buttons.
// Define IOCOND_SW_DEBOUNCE_EN to debounce switches as well; otherwise switches are only synchronised.
module io_input_conditioner #(
  parameter int SW_WIDTH       = 18,
  parameter int BTN_WIDTH      = 4,
  parameter int TICK_CYCLES    = 50000,
  parameter int DB_TICKS       = 10,
  parameter bit BTN_ACTIVE_LOW = 1'b1
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic [SW_WIDTH-1:0]  i_sw_raw,
  input  logic [BTN_WIDTH-1:0] i_btn_raw,
  output logic [31:0]          o_io_sw,
  output logic [BTN_WIDTH-1:0] o_io_btn,
  output logic [BTN_WIDTH-1:0] o_btn_press,
  output logic                 o_tick
);

  localparam int                   PC_W     = $clog2(TICK_CYCLES);
  localparam int                   DC_W     = $clog2(DB_TICKS + 1);
  localparam logic [PC_W-1:0]      PC_MAX   = PC_W'(TICK_CYCLES - 1);
  localparam logic [DC_W-1:0]      DC_MAX   = DC_W'(DB_TICKS - 1);
  localparam logic [BTN_WIDTH-1:0] BTN_IDLE = {BTN_WIDTH{BTN_ACTIVE_LOW}};

  // One debouncer step for a single bit; returns {stable, dc}.
  function automatic logic [DC_W:0] db_step(input logic s, input logic stable,
                                            input logic [DC_W-1:0] dc, input logic tick);
    logic [DC_W:0] r;
    r = {stable, dc};
    if (s == stable) begin
      r = {stable, {DC_W{1'b0}}};
    end else if (tick) begin
      if (dc == DC_MAX) r = {s, {DC_W{1'b0}}};
      else              r = {stable, dc + DC_W'(1)};
    end
    return r;
  endfunction

  logic [SW_WIDTH-1:0]  sw_meta_q, sw_meta_d, sw_sync_q, sw_sync_d;
  logic [BTN_WIDTH-1:0] btn_meta_q, btn_meta_d, btn_sync_q, btn_sync_d;
  logic [BTN_WIDTH-1:0] btn_s;
  logic [PC_W-1:0]      pc_q, pc_d;
  logic                 tick_q, tick_d;
  logic [BTN_WIDTH-1:0] btn_stable_q, btn_stable_d;
  logic [DC_W-1:0]      btn_dc_q [BTN_WIDTH];
  logic [DC_W-1:0]      btn_dc_d [BTN_WIDTH];
  logic [BTN_WIDTH-1:0] press_q, press_d;
  logic [SW_WIDTH-1:0]  sw_out;

  always_comb begin
    sw_meta_d  = i_sw_raw;
    sw_sync_d  = sw_meta_q;
    btn_meta_d = i_btn_raw;
    btn_sync_d = btn_meta_q;
    // XOR with the idle level makes 1 mean "pressed" for either pad polarity.
    btn_s      = btn_sync_q ^ BTN_IDLE;
    tick_d     = (pc_q == PC_MAX);
    pc_d       = tick_d ? '0 : pc_q + PC_W'(1);
    btn_stable_d = btn_stable_q;
    for (int i = 0; i < BTN_WIDTH; i++) begin
      btn_dc_d[i] = btn_dc_q[i];
      {btn_stable_d[i], btn_dc_d[i]} = db_step(btn_s[i], btn_stable_q[i], btn_dc_q[i], tick_q);
    end
    press_d = btn_stable_d & ~btn_stable_q;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      sw_meta_q    <= '0;
      sw_sync_q    <= '0;
      btn_meta_q   <= BTN_IDLE;
      btn_sync_q   <= BTN_IDLE;
      pc_q         <= '0;
      tick_q       <= 1'b0;
      btn_stable_q <= '0;
      press_q      <= '0;
      for (int i = 0; i < BTN_WIDTH; i++) btn_dc_q[i] <= '0;
    end else begin
      sw_meta_q    <= sw_meta_d;
      sw_sync_q    <= sw_sync_d;
      btn_meta_q   <= btn_meta_d;
      btn_sync_q   <= btn_sync_d;
      pc_q         <= pc_d;
      tick_q       <= tick_d;
      btn_stable_q <= btn_stable_d;
      press_q      <= press_d;
      for (int i = 0; i < BTN_WIDTH; i++) btn_dc_q[i] <= btn_dc_d[i];
    end
  end

`ifdef IOCOND_SW_DEBOUNCE_EN
  logic [SW_WIDTH-1:0] sw_stable_q, sw_stable_d;
  logic [DC_W-1:0]     sw_dc_q [SW_WIDTH];
  logic [DC_W-1:0]     sw_dc_d [SW_WIDTH];

  always_comb begin
    sw_stable_d = sw_stable_q;
    for (int i = 0; i < SW_WIDTH; i++) begin
      sw_dc_d[i] = sw_dc_q[i];
      {sw_stable_d[i], sw_dc_d[i]} = db_step(sw_sync_q[i], sw_stable_q[i], sw_dc_q[i], tick_q);
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      sw_stable_q <= '0;
      for (int i = 0; i < SW_WIDTH; i++) sw_dc_q[i] <= '0;
    end else begin
      sw_stable_q <= sw_stable_d;
      for (int i = 0; i < SW_WIDTH; i++) sw_dc_q[i] <= sw_dc_d[i];
    end
  end

  assign sw_out = sw_stable_q;
`else
  assign sw_out = sw_sync_q;
`endif

  assign o_io_sw     = 32'(sw_out);
  assign o_io_btn    = btn_stable_q;
  assign o_btn_press = press_q;
  assign o_tick      = tick_q;

endmodule

// File: tb/tb_io_input_conditioner.sv
// Randomised and directed bench for io_input_conditioner against a rule-level reference model.
module tb_io_input_conditioner;

  localparam int SW_W  = 18;
  localparam int BTN_W = 4;
  localparam int TICK  = 4;
  localparam int DB    = 3;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [SW_W-1:0]   sw_raw;
  logic [BTN_W-1:0]  btn_raw;
  logic [31:0]       io_sw;
  logic [BTN_W-1:0]  io_btn;
  logic [BTN_W-1:0]  btn_press;
  logic              tick;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  io_input_conditioner #(
    .SW_WIDTH(SW_W), .BTN_WIDTH(BTN_W), .TICK_CYCLES(TICK), .DB_TICKS(DB), .BTN_ACTIVE_LOW(1'b1)
  ) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_sw_raw(sw_raw), .i_btn_raw(btn_raw),
    .o_io_sw(io_sw), .o_io_btn(io_btn), .o_btn_press(btn_press), .o_tick(tick)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model: pad history in queues, tick from elapsed cycle count,
  // debounce as a count of consecutive ticks on which the sample disagreed.
  int              cyc;
  logic [BTN_W-1:0] btn_pipe[$];
  logic [SW_W-1:0]  sw_pipe[$];
  int              btn_run[BTN_W];
  logic [BTN_W-1:0] m_btn, m_press;
  logic [SW_W-1:0]  m_sw;
  logic            m_tick;
`ifdef IOCOND_SW_DEBOUNCE_EN
  int              sw_run[SW_W];
`endif

  task automatic model_reset();
    cyc      = 0;
    btn_pipe = '{4'hF, 4'hF};
    sw_pipe  = '{18'h0, 18'h0};
    m_btn    = '0;
    m_press  = '0;
    m_sw     = '0;
    m_tick   = 1'b0;
    for (int i = 0; i < BTN_W; i++) btn_run[i] = 0;
`ifdef IOCOND_SW_DEBOUNCE_EN
    for (int i = 0; i < SW_W; i++) sw_run[i] = 0;
`endif
  endtask

  task automatic model_edge();
    logic [BTN_W-1:0] s_btn;
    logic [BTN_W-1:0] prev;
    logic [SW_W-1:0]  s_sw;
    s_btn = ~btn_pipe[0];
    s_sw  = sw_pipe[0];
    prev  = m_btn;
    for (int i = 0; i < BTN_W; i++) begin
      if (s_btn[i] == m_btn[i]) btn_run[i] = 0;
      else if (m_tick) begin
        btn_run[i]++;
        if (btn_run[i] == DB) begin
          m_btn[i]   = s_btn[i];
          btn_run[i] = 0;
        end
      end
    end
`ifdef IOCOND_SW_DEBOUNCE_EN
    for (int i = 0; i < SW_W; i++) begin
      if (s_sw[i] == m_sw[i]) sw_run[i] = 0;
      else if (m_tick) begin
        sw_run[i]++;
        if (sw_run[i] == DB) begin
          m_sw[i]   = s_sw[i];
          sw_run[i] = 0;
        end
      end
    end
`endif
    m_press = m_btn & ~prev;
    void'(btn_pipe.pop_front());
    btn_pipe.push_back(btn_raw);
    void'(sw_pipe.pop_front());
    sw_pipe.push_back(sw_raw);
`ifndef IOCOND_SW_DEBOUNCE_EN
    m_sw = sw_pipe[0];
`endif
    cyc++;
    m_tick = (cyc % TICK == 0);
  endtask

  task automatic step();
    @(posedge clk);
    if (rst_n) model_edge();
    @(negedge clk);
    chk("io_btn", 32'(io_btn), 32'(m_btn));
    chk("btn_press", 32'(btn_press), 32'(m_press));
    chk("tick", 32'(tick), 32'(m_tick));
    chk("io_sw", io_sw, 32'(m_sw));
  endtask

  task automatic measure(input int b, output int lat, output int pulses);
    lat    = 999;
    pulses = 0;
    for (int k = 1; k <= 24; k++) begin
      step();
      if (io_btn[b] && lat == 999) lat = k;
      if (btn_press[b]) pulses++;
    end
  endtask

  initial begin
    int first, nticks, lat, pulses, cnt_a, cnt_any;
    logic [BTN_W-1:0] seen;
    sw_raw  = '0;
    btn_raw = 4'hF;
    model_reset();
    repeat (3) @(negedge clk);
    chk("rst_io_btn", 32'(io_btn), 32'h0);
    chk("rst_io_sw", io_sw, 32'h0);
    chk("rst_press", 32'(btn_press), 32'h0);
    chk("rst_tick", 32'(tick), 32'h0);
    rst_n = 1'b1;

    first  = -1;
    nticks = 0;
    for (int k = 1; k <= 12; k++) begin
      step();
      if (tick) begin
        nticks++;
        if (first < 0) first = k;
      end
    end
    chk("first_tick_cycle", 32'(first), 32'd4);
    chk("tick_count_12", 32'(nticks), 32'd3);

    btn_raw = 4'hE;
    repeat (6) step();
    btn_raw = 4'hF;
    seen    = '0;
    pulses  = 0;
    for (int k = 0; k < 20; k++) begin
      step();
      seen = seen | io_btn;
      if (btn_press != 0) pulses++;
    end
    chk("glitch_btn", 32'(seen), 32'h0);
    chk("glitch_press", 32'(pulses), 32'd0);

    btn_raw = 4'hE;
    measure(0, lat, pulses);
    chk("press_lat_in_11_15", 32'(lat >= 11 && lat <= 15), 32'd1);
    chk("press_pulses", 32'(pulses), 32'd1);
    chk("press_held", 32'(io_btn), 32'h1);

    btn_raw = 4'hF;
    measure(0, lat, pulses);
    chk("release_pulses", 32'(pulses), 32'd0);
    chk("release_btn", 32'(io_btn), 32'h0);

    btn_raw = 4'h5;
    cnt_a   = 0;
    cnt_any = 0;
    for (int k = 0; k < 24; k++) begin
      step();
      if (btn_press == 4'hA) cnt_a++;
      if (btn_press != 0) cnt_any++;
    end
    chk("multi_press_a", 32'(cnt_a), 32'd1);
    chk("multi_press_cycles", 32'(cnt_any), 32'd1);
    chk("multi_btn", 32'(io_btn), 32'hA);

    sw_raw = 18'h2A5A5;
`ifdef IOCOND_SW_DEBOUNCE_EN
    lat = 999;
    for (int k = 1; k <= 24; k++) begin
      step();
      if (io_sw == 32'h0002A5A5 && lat == 999) lat = k;
    end
    chk("sw_lat_in_11_15", 32'(lat >= 11 && lat <= 15), 32'd1);
`else
    step();
    chk("sw_after_1", io_sw, 32'h0);
    step();
    chk("sw_after_2", io_sw, 32'h0002A5A5);
`endif

    btn_raw = 4'hF;
    repeat (24) step();
    btn_raw = 4'hB;
    repeat (8) step();
    rst_n = 1'b0;
    #1;
    model_reset();
    chk("midrst_io_btn", 32'(io_btn), 32'h0);
    chk("midrst_io_sw", io_sw, 32'h0);
    chk("midrst_press", 32'(btn_press), 32'h0);
    chk("midrst_tick", 32'(tick), 32'h0);
    repeat (3) step();
    rst_n = 1'b1;
    measure(2, lat, pulses);
    chk("postrst_lat_in_11_15", 32'(lat >= 11 && lat <= 15), 32'd1);
    chk("postrst_pulses", 32'(pulses), 32'd1);

    for (int k = 0; k < 800; k++) begin
      if ($urandom_range(11, 0) == 0) btn_raw = btn_raw ^ 4'(1 << $urandom_range(3, 0));
      if ($urandom_range(39, 0) == 0) sw_raw = 18'($urandom);
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/io_input_conditioner.md
# io_input_conditioner

- Front-end conditioning stage for the board's slide switches and push-buttons.
- Synchronises raw pad inputs into `i_clk`, debounces them with a shared millisecond tick, and presents clean levels.
- Those levels drive the LSU's `i_io_sw` and `i_io_btn` ports, so software reads stable values at 0x7800/0x7810.
- Also produces one-cycle press pulses for other consumers.

## Interface
- `SW_WIDTH`, 18: number of physical switches (1..32).
- `BTN_WIDTH`, 4: number of physical buttons (1..32).
- `TICK_CYCLES`, 50000: `i_clk` cycles per debounce tick (≥2); 1 ms at 50 MHz.
- `DB_TICKS`, 10: consecutive disagreeing ticks needed to commit a change (≥1).
- `BTN_ACTIVE_LOW`, 1: if 1, raw button pads read 0 when pressed.

- `i_clk` in 1: system clock.
- `i_rst_n` in 1: reset. One clock; reset is asynchronous and active-low.
- `i_sw_raw` in SW_WIDTH: raw switch pads, asynchronous to `i_clk`.
- `i_btn_raw` in BTN_WIDTH: raw button pads, asynchronous to `i_clk`.
- `o_io_sw` out 32: conditioned switches, zero-extended above `SW_WIDTH`.
- `o_io_btn` out BTN_WIDTH: conditioned buttons; 1 = pressed, regardless of pad polarity.
- `o_btn_press` out BTN_WIDTH: one-cycle pulse per debounced press.
- `o_tick` out 1: prescaler tick, one cycle wide, exported for other timers.

## Operation
**Synchroniser**
- Two-flop chain per input bit.
- Button flops reset to the inactive pad level: all-ones if `BTN_ACTIVE_LOW`, else zeros.
- Switch flops reset to 0.
- The second flop output, inverted for buttons when `BTN_ACTIVE_LOW`, is the sampled value `s[i]`.

**Prescaler**
- Counter `pc`, width `$clog2(TICK_CYCLES)`.
- Increments every cycle and wraps from `TICK_CYCLES-1` to 0.
- `o_tick` is registered and asserts in the cycle after `pc == TICK_CYCLES-1`.
- `o_tick` is high exactly once per `TICK_CYCLES` cycles.

**Per-bit debouncer**
- State per bit: `stable[i]` plus counter `dc[i]`, width `$clog2(DB_TICKS+1)`.
- If `s[i] == stable[i]`: `dc[i] <= 0` on any cycle, tick or not.
- Else, on a tick cycle with `dc[i] == DB_TICKS-1`: `stable[i] <= s[i]` and `dc[i] <= 0`.
- Else, on a tick cycle: `dc[i] <= dc[i]+1`.
- Else (mismatch, no tick): hold.
- A glitch that returns before `DB_TICKS` consecutive ticks never reaches the output.
- `dc` never exceeds `DB_TICKS-1`; no wrap.

**Outputs**
- `o_io_btn = stable_btn`.
- `o_io_sw = {(32-SW_WIDTH) zeros, sw_out}`.
- `o_btn_press[i]` is registered: high for exactly the first cycle in which `o_io_btn[i]` reads 1.
- Releases generate no pulse.
- Simultaneous presses on several bits pulse in the same cycle.

**Reset** (async, takes effect immediately)
- All outputs are 0.
- `pc`, all `dc`, and all `stable` are 0.
- An in-progress debounce is discarded; after release a full `DB_TICKS` window is needed again.

## Timing
- Synchroniser latency: 2 cycles.
- Button latency, raw edge to `o_io_btn` change, for an input held steady: between `2 + (DB_TICKS-1)*TICK_CYCLES + 1` and `2 + DB_TICKS*TICK_CYCLES + 1` cycles, depending on tick phase.
- `o_btn_press` is coincident with the `o_io_btn` rising edge.
- First `o_tick` after reset release: cycle `TICK_CYCLES`, counting the first post-reset cycle as 1.
- No handshake: outputs are level signals, valid every cycle.

## Configuration
- Macro: `IOCOND_SW_DEBOUNCE_EN`.
- Defined: switches pass through the same tick/`DB_TICKS` debouncer as buttons, with the same latency bounds.
- Undefined: no switch debounce counters are built; `sw_out = s` directly, giving exactly 2 cycles of raw-to-output latency.
- Buttons are always debounced.

## Test plan
Bench parameters: `TICK_CYCLES=4`, `DB_TICKS=3`, `BTN_ACTIVE_LOW=1`.
1. **Reset.** `i_btn_raw=4'hF`, `i_sw_raw=0`, reset held then released → `o_io_btn=0`, `o_io_sw=0`, `o_btn_press=0`; `o_tick` first high at cycle 4, then every 4 cycles.
2. **Press.** `i_btn_raw` bit0 driven to 0 and held → `o_io_btn=4'h1` within 11–15 cycles; `o_btn_press=4'h1` for exactly one cycle; remains 1 while held with no further pulses.
3. **Glitch.** Bit0 low for 6 cycles (≤2 ticks), then high → `o_io_btn` stays 0, no press pulse, `dc[0]` back to 0.
4. **Release and multi-press.** Release bit0 → `o_io_btn` returns to 0 with no pulse. Then press bits 1 and 3 together → `o_io_btn=4'hA` and `o_btn_press=4'hA` in the same single cycle.
5. **Switch.** `i_sw_raw=18'h2A5A5` → `o_io_sw=32'h0002A5A5`: exactly 2 cycles later with the macro undefined; 11–15 cycles later with the macro defined.
6. **Reset mid-count.** Bit2 pressed; assert `i_rst_n=0` after 2 ticks → all outputs 0 immediately. Release reset with the button still held → `o_io_btn[2]` rises only after 3 full post-reset ticks (11–15 cycles), with one press pulse.
